// File: rtl/crack_scheduler.sv
`default_nettype none
// ============================================================================
// crack_scheduler: dispatches ascending keys to a pool of ARC4 crack engines,
// arbitrates the shared ciphertext port and returns the smallest passing key.
// Revision: 1.0
// ============================================================================
module crack_scheduler #(
  parameter int N_ENG = 2,
  parameter int KEY_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               rdy,
  output logic [KEY_W-1:0]   key,
  output logic               key_valid,
  output logic [N_ENG-1:0]   eng_start,
  output logic [KEY_W-1:0]   eng_key,
  input  logic [N_ENG-1:0]   eng_rdy,
  input  logic [N_ENG-1:0]   eng_done,
  input  logic [N_ENG-1:0]   eng_pass,
  input  logic [N_ENG-1:0]   eng_ct_req,
  input  logic [8*N_ENG-1:0] eng_ct_addr,
  output logic [N_ENG-1:0]   eng_ct_gnt,
  output logic [7:0]         ct_addr
);

  localparam int PW = $clog2(N_ENG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] next_key;
  logic [KEY_W-1:0] best;
  logic             found;
  logic             exhausted;
  logic [N_ENG-1:0] busy;
  logic [KEY_W-1:0] inflight [N_ENG];
  logic [PW-1:0]    dptr;
  logic [PW-1:0]    aptr;

  // Round-robin pick of the next idle engine, starting at dptr.
  logic [N_ENG-1:0] eligible;
  logic             disp_ok;
  logic [PW-1:0]    disp_idx;

  always_comb begin
    eligible = eng_rdy & ~busy;
    disp_ok  = 1'b0;
    disp_idx = '0;
    for (int k = 0; k < N_ENG; k++) begin
      if (!disp_ok && eligible[dptr + PW'(k)]) begin
        disp_ok  = 1'b1;
        disp_idx = dptr + PW'(k);
      end
    end
  end

  // Completions from busy engines only; simultaneous passes reduce to their minimum key.
  logic [N_ENG-1:0] done_v;
  logic             pass_any;
  logic [KEY_W-1:0] pass_min;

  always_comb begin
    done_v   = eng_done & busy;
    pass_any = 1'b0;
    pass_min = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (done_v[i] && eng_pass[i] && (!pass_any || inflight[i] < pass_min)) begin
        pass_any = 1'b1;
        pass_min = inflight[i];
      end
    end
  end

  logic             arb_ok;
  logic [PW-1:0]    arb_idx;

  always_comb begin
    arb_ok     = 1'b0;
    arb_idx    = '0;
    eng_ct_gnt = '0;
    ct_addr    = '0;
    for (int k = 0; k < N_ENG; k++) begin
      if (!arb_ok && eng_ct_req[aptr + PW'(k)]) begin
        arb_ok  = 1'b1;
        arb_idx = aptr + PW'(k);
      end
    end
    if (arb_ok) begin
      eng_ct_gnt[arb_idx] = 1'b1;
      ct_addr             = eng_ct_addr[int'(arb_idx)*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      key       <= '0;
      key_valid <= 1'b0;
      eng_start <= '0;
      eng_key   <= '0;
      next_key  <= '0;
      best      <= '0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      busy      <= '0;
      dptr      <= '0;
      aptr      <= '0;
      for (int i = 0; i < N_ENG; i++) inflight[i] <= '0;
    end else begin
      eng_start <= '0;
      if (arb_ok) aptr <= arb_idx + 1'b1;

      if (state != IDLE) begin
        busy <= busy & ~done_v;
        if (pass_any && (!found || pass_min < best)) begin
          best  <= pass_min;
          found <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (en) begin
            state     <= RUN;
            rdy       <= 1'b0;
            key       <= '0;
            key_valid <= 1'b0;
            next_key  <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            busy      <= '0;
          end
        end
        RUN: begin
          // A pass blocks dispatch on the same edge so no higher key is launched.
          if (pass_any) begin
            state <= DRAIN;
          end else if (disp_ok && !exhausted) begin
            eng_start[disp_idx] <= 1'b1;
            eng_key             <= next_key;
            busy[disp_idx]      <= 1'b1;
            inflight[disp_idx]  <= next_key;
            next_key            <= next_key + 1'b1;
            dptr                <= disp_idx + 1'b1;
            if (&next_key) begin
              exhausted <= 1'b1;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (busy == '0) begin
            state     <= DONE;
            rdy       <= 1'b1;
            key       <= best;
            key_valid <= found;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crack_scheduler.sv
`default_nettype none
// ============================================================================
// tb_crack_scheduler: directed bench with behavioural engine models.
// Revision: 1.0
// ============================================================================
module tb_crack_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        rdy_a, rdy_b, kv_a, kv_b;
  logic [23:0] key_a, ekey_a;
  logic [3:0]  key_b, ekey_b;
  logic [1:0]  start_a, start_b, gnt_a, gnt_b;
  logic [7:0]  ct_a, ct_b;
  logic [1:0]  eng_rdy = 2'b11, eng_done = 2'b00, eng_pass = 2'b00;
  logic [1:0]  ct_req = 2'b00;
  logic [15:0] ct_addr_in = 16'h0;

  crack_scheduler #(.N_ENG(2), .KEY_W(24)) u_dut (
    .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .key(key_a), .key_valid(kv_a),
    .eng_start(start_a), .eng_key(ekey_a), .eng_rdy(eng_rdy), .eng_done(eng_done),
    .eng_pass(eng_pass), .eng_ct_req(ct_req), .eng_ct_addr(ct_addr_in),
    .eng_ct_gnt(gnt_a), .ct_addr(ct_a));

  crack_scheduler #(.N_ENG(2), .KEY_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .key(key_b), .key_valid(kv_b),
    .eng_start(start_b), .eng_key(ekey_b), .eng_rdy(eng_rdy), .eng_done(eng_done),
    .eng_pass(eng_pass), .eng_ct_req(ct_req), .eng_ct_addr(ct_addr_in),
    .eng_ct_gnt(gnt_b), .ct_addr(ct_b));

  int checks = 0;
  int errors = 0;

  // Engine-model configuration, set by each scenario before starting a run.
  logic        sel = 1'b0;
  int          def_lat = 6;
  logic [23:0] long_key = 24'hFFFFFF, short_key = 24'hFFFFFF;
  int          long_lat = 30, short_lat = 2;
  logic [23:0] pk0 = 24'h0, pk1 = 24'h0;
  logic        pass_en0 = 1'b0, pass_en1 = 1'b0;

  logic [1:0]  m_start;
  logic [23:0] m_key;
  assign m_start = sel ? start_b : start_a;
  assign m_key   = sel ? {20'd0, ekey_b} : ekey_a;

  logic [23:0] lg_key[$];
  int          lg_eng[$];
  logic [1:0]  active = 2'b00;
  int          cnt [2];
  logic [23:0] ek [2];

  function automatic int lat_of(input logic [23:0] k);
    if (k == long_key)  return long_lat;
    if (k == short_key) return short_lat;
    return def_lat;
  endfunction

  function automatic logic pass_of(input logic [23:0] k);
    return (pass_en0 && k == pk0) || (pass_en1 && k == pk1);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      eng_done[i] = 1'b0;
      eng_pass[i] = 1'b0;
      if (rst) begin
        active[i] = 1'b0;
      end else if (m_start[i]) begin
        active[i] = 1'b1;
        ek[i]     = m_key;
        cnt[i]    = lat_of(m_key);
        lg_key.push_back(m_key);
        lg_eng.push_back(i);
      end else if (active[i]) begin
        if (cnt[i] <= 1) begin
          active[i]   = 1'b0;
          eng_done[i] = 1'b1;
          eng_pass[i] = pass_of(ek[i]);
        end else begin
          cnt[i] = cnt[i] - 1;
        end
      end
    end
    eng_rdy = ~active;
  end

  task automatic configure(input int dl, input logic [23:0] lk, input int ll,
                           input logic [23:0] sk, input int sl,
                           input logic e0, input logic [23:0] p0,
                           input logic e1, input logic [23:0] p1);
    def_lat = dl; long_key = lk; long_lat = ll; short_key = sk; short_lat = sl;
    pass_en0 = e0; pk0 = p0; pass_en1 = e1; pk1 = p1;
  endtask

  // Pulses en for one edge (E0) and returns at the negedge after E0.
  task automatic start_run(input logic which);
    @(negedge clk);
    lg_key.delete();
    lg_eng.delete();
    if (which) en_b = 1'b1; else en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  task automatic wait_rdy(input logic which, input int budget, output logic ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = which ? rdy_b : rdy_a;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy_a, kv_a, start_a, gnt_a} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=100000", {rdy_a, kv_a, start_a, gnt_a});
    end
    checks++;
    if ({key_a, ekey_a, ct_a} !== 56'h0) begin
      errors++; $display("FAIL reset_data got key=%h ekey=%h ct=%h exp=0", key_a, ekey_a, ct_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal;
    logic ok, bad;
    sel = 1'b0;
    configure(6, 24'hFFFFFF, 30, 24'hFFFFFF, 2, 1'b1, 24'h000018, 1'b0, 24'h0);
    start_run(1'b0);
    checks++;
    if ({rdy_a, start_a} !== 3'b000) begin
      errors++; $display("FAIL start_e0 got rdy/start=%b exp=000", {rdy_a, start_a});
    end
    @(negedge clk);
    checks++;
    if (start_a !== 2'b01 || ekey_a !== 24'h0) begin
      errors++; $display("FAIL first_dispatch got start=%b key=%h exp start=01 key=0", start_a, ekey_a);
    end
    wait_rdy(1'b0, 600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL normal_timeout got rdy=0 exp rdy=1"); end
    checks++;
    if (kv_a !== 1'b1 || key_a !== 24'h000018) begin
      errors++; $display("FAIL normal_result got key=%h valid=%b exp key=000018 valid=1", key_a, kv_a);
    end
    bad = (lg_key.size() != 26);
    foreach (lg_key[j]) if (lg_key[j] !== 24'(j) || lg_eng[j] != (j % 2)) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL normal_order got count=%0d exp count=26 keys 0..0x19 alternating", lg_key.size()); end
  endtask

  task automatic test_out_of_order;
    logic ok;
    configure(6, 24'h3, 30, 24'h4, 2, 1'b1, 24'h3, 1'b1, 24'h4);
    start_run(1'b0);
    checks++;
    if (kv_a !== 1'b0 || key_a !== 24'h0) begin
      errors++; $display("FAIL result_clear got key=%h valid=%b exp key=0 valid=0", key_a, kv_a);
    end
    wait_rdy(1'b0, 300, ok);
    checks++;
    if (!ok || kv_a !== 1'b1 || key_a !== 24'h3) begin
      errors++; $display("FAIL ooo_result got key=%h valid=%b rdy=%b exp key=000003 valid=1 rdy=1", key_a, kv_a, ok);
    end
    checks++;
    if (lg_key.size() != 5) begin errors++; $display("FAIL ooo_count got=%0d exp=5", lg_key.size()); end
  endtask

  task automatic test_simultaneous;
    logic ok;
    configure(6, 24'h5, 13, 24'hFFFFFF, 2, 1'b1, 24'h5, 1'b1, 24'h6);
    start_run(1'b0);
    wait_rdy(1'b0, 300, ok);
    checks++;
    if (!ok || kv_a !== 1'b1 || key_a !== 24'h5) begin
      errors++; $display("FAIL simul_result got key=%h valid=%b rdy=%b exp key=000005 valid=1 rdy=1", key_a, kv_a, ok);
    end
    checks++;
    if (lg_key.size() != 7) begin errors++; $display("FAIL simul_count got=%0d exp=7", lg_key.size()); end
  endtask

  task automatic test_reset_midrun;
    logic bad;
    configure(6, 24'hFFFFFF, 30, 24'hFFFFFF, 2, 1'b0, 24'h0, 1'b0, 24'h0);
    start_run(1'b0);
    repeat (10) @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (rdy_a !== 1'b0) begin errors++; $display("FAIL en_ignored_rdy got=%b exp=0", rdy_a); end
    bad = (lg_key.size() < 6);
    foreach (lg_key[j]) if (lg_key[j] !== 24'(j)) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL en_ignored_keys got count=%0d exp ascending keys without restart", lg_key.size()); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy_a, kv_a, start_a} !== 4'b1000 || key_a !== 24'h0) begin
      errors++; $display("FAIL midrun_reset got rdy/kv/start=%b key=%h exp 1000 key=0", {rdy_a, kv_a, start_a}, key_a);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_exhaustion;
    logic ok, bad;
    sel = 1'b1;
    configure(3, 24'hFFFFFF, 30, 24'hFFFFFF, 2, 1'b0, 24'h0, 1'b0, 24'h0);
    start_run(1'b1);
    wait_rdy(1'b1, 300, ok);
    checks++;
    if (!ok || kv_b !== 1'b0) begin
      errors++; $display("FAIL exhaust_done got rdy=%b valid=%b exp rdy=1 valid=0", ok, kv_b);
    end
    bad = (lg_key.size() != 16);
    foreach (lg_key[j]) if (lg_key[j] !== 24'(j)) bad = 1'b1;
    checks++;
    if (bad) begin errors++; $display("FAIL exhaust_order got count=%0d exp count=16 keys 0..15", lg_key.size()); end
    start_run(1'b1);
    @(negedge clk);
    checks++;
    if (start_b !== 2'b01 || ekey_b !== 4'h0) begin
      errors++; $display("FAIL exhaust_restart got start=%b key=%h exp start=01 key=0", start_b, ekey_b);
    end
    wait_rdy(1'b1, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_timeout got rdy=0 exp rdy=1"); end
    sel = 1'b0;
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_g;
    @(negedge clk);
    ct_addr_in = {8'h20, 8'h10};
    ct_req     = 2'b11;
    exp_g      = 2'b01;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (gnt_a !== exp_g || ct_a !== (exp_g[0] ? 8'h10 : 8'h20)) begin
        errors++; $display("FAIL arb_alt cyc=%0d got gnt=%b addr=%h exp gnt=%b", c, gnt_a, ct_a, exp_g);
      end
      exp_g = ~exp_g;
      @(negedge clk);
    end
    ct_req = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (gnt_a !== 2'b10 || ct_a !== 8'h20) begin
        errors++; $display("FAIL arb_lone cyc=%0d got gnt=%b addr=%h exp gnt=10 addr=20", c, gnt_a, ct_a);
      end
      @(negedge clk);
    end
    ct_req = 2'b00;
    #1;
    checks++;
    if (gnt_a !== 2'b00 || ct_a !== 8'h00) begin
      errors++; $display("FAIL arb_none got gnt=%b addr=%h exp gnt=00 addr=00", gnt_a, ct_a);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_out_of_order();
    test_simultaneous();
    test_reset_midrun();
    test_exhaustion();
    test_arbitration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
